// File: rtl/rx_eth.sv
// Ethernet receive framer: writes each frame into a circular QW buffer as a length header
// followed by its data QWs. Optional dropped-frame counter under `ifdef RX_DROP_CNT_EN.
module rx_eth #(
   parameter int BW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [63:0]   rx_data,
   input  logic [7:0]    rx_data_valid,
   input  logic          rx_good_frame,
   input  logic          rx_bad_frame,
   output logic [BW-1:0] wr_addr,
   output logic [63:0]   wr_data,
   output logic          wr_en,
   output logic [BW:0]   committed_prod,
   input  logic [BW:0]   committed_cons
`ifdef RX_DROP_CNT_EN
   ,
   output logic [31:0]   dropped_frames
`endif
);

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   localparam logic [BW:0]   DEPTH    = {1'b1, {BW{1'b0}}};
   localparam logic [BW:0]   PTR_ONE  = {{BW{1'b0}}, 1'b1};
   localparam logic [BW:0]   PTR_TWO  = {{(BW-1){1'b0}}, 2'b10};
   localparam logic [BW-1:0] ADDR_ONE = {{(BW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [BW:0]   wr_ptr_q, wr_ptr_d;
   logic [BW:0]   sof_q, sof_d;
   logic [15:0]   byte_len_q, byte_len_d;
   logic          wr_en_q, wr_en_d;
   logic [BW-1:0] wr_addr_q, wr_addr_d;
   logic [63:0]   wr_data_q, wr_data_d;
   logic [BW:0]   prod_q, prod_d;
   logic          pend_q, pend_d;
   logic [BW:0]   pend_ptr_q, pend_ptr_d;

   logic [3:0]    beat_bytes;
   logic [BW:0]   used;
   logic [BW:0]   free;
   logic [16:0]   len_sum;
   logic [15:0]   len_sat;

   always_comb begin
      beat_bytes = 4'd0;
      for (int i = 0; i < 8; i++) begin
         beat_bytes = beat_bytes + 4'(rx_data_valid[i]);
      end
   end

   // Occupancy is measured from the write pointer, so QWs of an uncommitted frame count as used.
   assign used    = wr_ptr_q - committed_cons;
   assign free    = DEPTH - used;
   assign len_sum = {1'b0, byte_len_q} + 17'(beat_bytes);
   assign len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      sof_d      = sof_q;
      byte_len_d = byte_len_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      pend_d     = 1'b0;
      pend_ptr_d = pend_ptr_q;
      prod_d     = pend_q ? pend_ptr_q : prod_q;

      unique case (state_q)
         IDLE: begin
            if (rx_data_valid != 8'h00) begin
               sof_d = wr_ptr_q;
               if (free >= PTR_TWO) begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = wr_ptr_q[BW-1:0] + ADDR_ONE;
                  wr_data_d  = rx_data;
                  wr_ptr_d   = wr_ptr_q + PTR_TWO;
                  byte_len_d = {12'd0, beat_bytes};
                  state_d    = RECV;
               end else begin
                  state_d = DROP;
               end
            end
         end
         RECV: begin
            if (rx_good_frame) begin
               // Header goes out now; the producer pointer follows a cycle later so it never leads the header.
               wr_en_d    = 1'b1;
               wr_addr_d  = sof_q[BW-1:0];
               wr_data_d  = {48'd0, byte_len_q};
               pend_d     = 1'b1;
               pend_ptr_d = wr_ptr_q;
               state_d    = IDLE;
            end else if (rx_bad_frame) begin
               wr_ptr_d = sof_q;
               state_d  = IDLE;
            end else if (rx_data_valid != 8'h00) begin
               if (used < DEPTH) begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = wr_ptr_q[BW-1:0];
                  wr_data_d  = rx_data;
                  wr_ptr_d   = wr_ptr_q + PTR_ONE;
                  byte_len_d = len_sat;
               end else begin
                  state_d = DROP;
               end
            end
         end
         DROP: begin
            if (rx_good_frame || rx_bad_frame) begin
               wr_ptr_d = sof_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         sof_q      <= '0;
         byte_len_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         prod_q     <= '0;
         pend_q     <= 1'b0;
         pend_ptr_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         sof_q      <= sof_d;
         byte_len_q <= byte_len_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         prod_q     <= prod_d;
         pend_q     <= pend_d;
         pend_ptr_q <= pend_ptr_d;
      end
   end

   assign wr_en          = wr_en_q;
   assign wr_addr        = wr_addr_q;
   assign wr_data        = wr_data_q;
   assign committed_prod = prod_q;

`ifdef RX_DROP_CNT_EN
   logic [31:0] drop_cnt_q, drop_cnt_d;
   logic        drop_inc;

   // A frame is lost when it is aborted while receiving or when it leaves the discard state.
   assign drop_inc = ((state_q == RECV) && rx_bad_frame && !rx_good_frame) ||
                     ((state_q == DROP) && (rx_good_frame || rx_bad_frame));

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_inc && (drop_cnt_q != 32'hFFFF_FFFF)) begin
         drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign dropped_frames = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rx_eth.sv
// Directed self-checking bench for rx_eth (BW=9); the wrap case uses the BW=9 analogue
// of the 1020/1024 scenario (508 -> 509..511, 0..4, producer 517).
module tb_rx_eth;

   localparam int BW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   rx_data;
   logic [7:0]    rx_data_valid;
   logic          rx_good_frame;
   logic          rx_bad_frame;
   logic [BW-1:0] wr_addr;
   logic [63:0]   wr_data;
   logic          wr_en;
   logic [BW:0]   committed_prod;
   logic [BW:0]   committed_cons;
`ifdef RX_DROP_CNT_EN
   logic [31:0]   dropped_frames;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;

   rx_eth #(.BW(BW)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_data        (rx_data),
      .rx_data_valid  (rx_data_valid),
      .rx_good_frame  (rx_good_frame),
      .rx_bad_frame   (rx_bad_frame),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .committed_prod (committed_prod),
      .committed_cons (committed_cons)
`ifdef RX_DROP_CNT_EN
      ,
      .dropped_frames (dropped_frames)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en === 1'b1) wr_cnt++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [63:0] pat(input logic [7:0] id, input int i);
      return {8'hA5, id, 32'h0, 16'(i)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rx_data       = '0;
      rx_data_valid = '0;
      rx_good_frame = 1'b0;
      rx_bad_frame  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send_beats(input int n, input logic [7:0] last, input logic [7:0] id);
      for (int i = 0; i < n; i++) begin
         rx_data       = pat(id, i);
         rx_data_valid = (i == n - 1) ? last : 8'hFF;
         tick();
      end
      rx_data       = '0;
      rx_data_valid = '0;
      tick();
   endtask

   task automatic strobe(input bit good);
      if (good) rx_good_frame = 1'b1;
      else      rx_bad_frame  = 1'b1;
      tick();
      rx_good_frame = 1'b0;
      rx_bad_frame  = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      committed_cons = '0;
      rst = 1'b1;
      tick();
      tick();
      tick();
      n_checks++;
      if (wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_en: got %b want 0", wr_en); end
      n_checks++;
      if (wr_addr !== '0) begin n_fail++; $display("[TB] FAIL reset_wr_addr: got %0d want 0", wr_addr); end
      n_checks++;
      if (wr_data !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_wr_data: got %h want 0", wr_data); end
      n_checks++;
      if (committed_prod !== '0) begin n_fail++; $display("[TB] FAIL reset_prod: got %0d want 0", committed_prod); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_good_frame();
      for (int i = 0; i < 8; i++) begin
         rx_data       = pat(8'd1, i);
         rx_data_valid = 8'hFF;
         tick();
         n_checks++;
         if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'(i + 1), pat(8'd1, i)}) begin
            n_fail++;
            $display("[TB] FAIL good_beat%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                     i, wr_en, wr_addr, wr_data, i + 1, pat(8'd1, i));
         end
      end
      idle_inputs();
      tick();
      n_checks++;
      if (wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL good_gap_en: got %b want 0", wr_en); end
      strobe(1'b1);
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'd0, 64'h40}) begin
         n_fail++;
         $display("[TB] FAIL good_header: got en=%b addr=%0d data=%h want en=1 addr=0 data=40", wr_en, wr_addr, wr_data);
      end
      n_checks++;
      if (committed_prod !== 10'd0) begin n_fail++; $display("[TB] FAIL good_prod_early: got %0d want 0", committed_prod); end
      tick();
      n_checks++;
      if (committed_prod !== 10'd9) begin n_fail++; $display("[TB] FAIL good_prod: got %0d want 9", committed_prod); end
   endtask

   task automatic test_short_frame();
      int c0;
      c0 = wr_cnt;
      send_beats(8, 8'h1F, 8'd2);
      strobe(1'b1);
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'd9, 64'd61}) begin
         n_fail++;
         $display("[TB] FAIL short_header: got en=%b addr=%0d data=%0d want en=1 addr=9 data=61", wr_en, wr_addr, wr_data);
      end
      tick();
      n_checks++;
      if (committed_prod !== 10'd18) begin n_fail++; $display("[TB] FAIL short_prod: got %0d want 18", committed_prod); end
      n_checks++;
      if (wr_cnt - c0 !== 9) begin n_fail++; $display("[TB] FAIL short_writes: got %0d want 9", wr_cnt - c0); end
   endtask

   task automatic test_bad_then_good();
      int c0;
      do_reset();
      committed_cons = '0;
      c0 = wr_cnt;
      strobe(1'b1);
      tick();
      n_checks++;
      if ((wr_cnt - c0 !== 0) || (committed_prod !== 10'd0)) begin
         n_fail++;
         $display("[TB] FAIL idle_strobe: got writes=%0d prod=%0d want writes=0 prod=0", wr_cnt - c0, committed_prod);
      end
      send_beats(8, 8'hFF, 8'd3);
      strobe(1'b0);
      n_checks++;
      if (wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_no_header: got en=%b want 0", wr_en); end
      tick();
      n_checks++;
      if (committed_prod !== 10'd0) begin n_fail++; $display("[TB] FAIL bad_prod: got %0d want 0", committed_prod); end
      send_beats(8, 8'hFF, 8'd4);
      strobe(1'b1);
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'd0, 64'h40}) begin
         n_fail++;
         $display("[TB] FAIL bad_good_header: got en=%b addr=%0d data=%h want en=1 addr=0 data=40", wr_en, wr_addr, wr_data);
      end
      tick();
      n_checks++;
      if (committed_prod !== 10'd9) begin n_fail++; $display("[TB] FAIL bad_good_prod: got %0d want 9", committed_prod); end
`ifdef RX_DROP_CNT_EN
      n_checks++;
      if (dropped_frames !== 32'd1) begin n_fail++; $display("[TB] FAIL bad_dropcnt: got %0d want 1", dropped_frames); end
`endif
   endtask

   task automatic test_overflow();
      int c0;
      do_reset();
      committed_cons = '0;
      for (int f = 0; f < 5; f++) begin
         send_beats(99, 8'hFF, 8'(f + 5));
         strobe(1'b1);
         tick();
      end
      n_checks++;
      if (committed_prod !== 10'd500) begin n_fail++; $display("[TB] FAIL fill_prod: got %0d want 500", committed_prod); end
      c0 = wr_cnt;
      send_beats(20, 8'hFF, 8'd10);
      n_checks++;
      if (wr_cnt - c0 !== 11) begin n_fail++; $display("[TB] FAIL ovf_writes: got %0d want 11", wr_cnt - c0); end
      strobe(1'b1);
      n_checks++;
      if (wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_no_header: got en=%b want 0", wr_en); end
      tick();
      tick();
      n_checks++;
      if (committed_prod !== 10'd500) begin n_fail++; $display("[TB] FAIL ovf_prod: got %0d want 500", committed_prod); end
`ifdef RX_DROP_CNT_EN
      n_checks++;
      if (dropped_frames !== 32'd1) begin n_fail++; $display("[TB] FAIL ovf_dropcnt: got %0d want 1", dropped_frames); end
`endif
      committed_cons = 10'd500;
      send_beats(7, 8'hFF, 8'd11);
      strobe(1'b1);
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'd500, 64'd56}) begin
         n_fail++;
         $display("[TB] FAIL ovf_next_header: got en=%b addr=%0d data=%0d want en=1 addr=500 data=56", wr_en, wr_addr, wr_data);
      end
      tick();
      n_checks++;
      if (committed_prod !== 10'd508) begin n_fail++; $display("[TB] FAIL ovf_next_prod: got %0d want 508", committed_prod); end
   endtask

   task automatic test_wrap();
      logic [8:0] ea;
      committed_cons = 10'd508;
      for (int i = 0; i < 8; i++) begin
         rx_data       = pat(8'd12, i);
         rx_data_valid = 8'hFF;
         tick();
         ea = 9'(509 + i);
         n_checks++;
         if ({wr_en, wr_addr} !== {1'b1, ea}) begin
            n_fail++;
            $display("[TB] FAIL wrap_beat%0d: got en=%b addr=%0d want en=1 addr=%0d", i, wr_en, wr_addr, ea);
         end
      end
      idle_inputs();
      tick();
      strobe(1'b1);
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'd508, 64'h40}) begin
         n_fail++;
         $display("[TB] FAIL wrap_header: got en=%b addr=%0d data=%h want en=1 addr=508 data=40", wr_en, wr_addr, wr_data);
      end
      tick();
      n_checks++;
      if (committed_prod !== 10'd517) begin n_fail++; $display("[TB] FAIL wrap_prod: got %0d want 517", committed_prod); end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 3; i++) begin
         rx_data       = pat(8'd13, i);
         rx_data_valid = 8'hFF;
         tick();
      end
      rx_data = pat(8'd13, 3);
      rst     = 1'b1;
      tick();
      n_checks++;
      if (wr_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_en: got %b want 0", wr_en); end
      rst = 1'b0;
      idle_inputs();
      tick();
      n_checks++;
      if (committed_prod !== 10'd0) begin n_fail++; $display("[TB] FAIL rstmid_prod: got %0d want 0", committed_prod); end
      committed_cons = '0;
      send_beats(2, 8'hFF, 8'd14);
      strobe(1'b1);
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'd0, 64'd16}) begin
         n_fail++;
         $display("[TB] FAIL rstmid_header: got en=%b addr=%0d data=%0d want en=1 addr=0 data=16", wr_en, wr_addr, wr_data);
      end
      tick();
      n_checks++;
      if (committed_prod !== 10'd3) begin n_fail++; $display("[TB] FAIL rstmid_next_prod: got %0d want 3", committed_prod); end
   endtask

   task automatic test_back_to_back();
      send_beats(2, 8'hFF, 8'd15);
      strobe(1'b1);
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'd3, 64'd16}) begin
         n_fail++;
         $display("[TB] FAIL b2b_header_a: got en=%b addr=%0d data=%0d want en=1 addr=3 data=16", wr_en, wr_addr, wr_data);
      end
      rx_data       = pat(8'd16, 0);
      rx_data_valid = 8'h07;
      tick();
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'd7, pat(8'd16, 0)}) begin
         n_fail++;
         $display("[TB] FAIL b2b_first_beat: got en=%b addr=%0d data=%h want en=1 addr=7 data=%h",
                  wr_en, wr_addr, wr_data, pat(8'd16, 0));
      end
      n_checks++;
      if (committed_prod !== 10'd6) begin n_fail++; $display("[TB] FAIL b2b_prod_a: got %0d want 6", committed_prod); end
      idle_inputs();
      tick();
      strobe(1'b1);
      n_checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 9'd6, 64'd3}) begin
         n_fail++;
         $display("[TB] FAIL b2b_header_b: got en=%b addr=%0d data=%0d want en=1 addr=6 data=3", wr_en, wr_addr, wr_data);
      end
      tick();
      n_checks++;
      if (committed_prod !== 10'd8) begin n_fail++; $display("[TB] FAIL b2b_prod_b: got %0d want 8", committed_prod); end
   endtask

   initial begin
      idle_inputs();
      rst            = 1'b1;
      committed_cons = '0;
      test_reset();
      test_good_frame();
      test_short_frame();
      test_bad_then_good();
      test_overflow();
      test_wrap();
      test_reset_mid_frame();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_eth.md
RX_ETH -- requirements
Module: rx_eth

Interface
REQ-001 Parameter: BW, default 9, log2 of the receive buffer depth in 64-bit quadwords (QWs).
REQ-002 clk  in  1  clock; all logic is rising-edge.
REQ-003 rst  in  1  reset: synchronous, active-high.
REQ-004 rx_data  in  64  MAC receive data; byte 0 is in bits [7:0].
REQ-005 rx_data_valid  in  8  per-byte valid, contiguous from the LSB; 0xFF on every non-final beat; 0x00 means idle.
REQ-006 rx_good_frame  in  1  one-cycle strobe that ends a good frame, at least 1 cycle after the last beat.
REQ-007 rx_bad_frame  in  1  one-cycle strobe that ends a bad frame (FCS or length error), same timing as rx_good_frame.
REQ-008 wr_addr  out  BW  buffer write address.
REQ-009 wr_data  out  64  buffer write data.
REQ-010 wr_en  out  1  buffer write strobe.
REQ-011 committed_prod  out  BW+1  producer pointer, published to the bwd logic.
REQ-012 committed_cons  in  BW+1  consumer pointer, returned from the bwd logic.
REQ-013 dropped_frames  out  32  dropped-frame count; present only under RX_DROP_CNT_EN.

Function
REQ-014 Pointers are BW+1 bits wide and wrap modulo 2^(BW+1).
REQ-015 Buffer address = pointer[BW-1:0].
REQ-016 free = 2^BW - (wr_ptr - committed_cons), computed mod 2^(BW+1).
REQ-017 Frame layout in the buffer: header QW at the sof address, data QWs at sof+1 onward, in order.
REQ-018 Header QW = {48'b0, byte_len[15:0]}; byte_len = total valid bytes in the frame.
REQ-019 All write-port outputs and committed_prod are registered.
REQ-020 Data latency: a beat sampled at cycle t produces wr_en=1 at cycle t+1.
REQ-021 FSM states: IDLE, RECV, DROP.
REQ-022 IDLE, nonzero rx_data_valid and free>=2: sof<=wr_ptr; write beat at wr_ptr+1; byte_len<=popcount(valid); go to RECV.
REQ-023 IDLE, nonzero rx_data_valid and free<2: no write; go to DROP.
REQ-024 IDLE, rx_good_frame or rx_bad_frame: ignored; no state change.
REQ-025 RECV, nonzero valid and space remains (next address - committed_cons < 2^BW): write the beat; byte_len += popcount(valid).
REQ-026 RECV, nonzero valid and no space remains: no write; go to DROP.
REQ-027 RECV, rx_good_frame at cycle t: header write at cycle t+1; committed_prod <= sof+1+data QW count at cycle t+2; go to IDLE.
REQ-028 A new frame's first beat is accepted in the cycle after rx_good_frame.
REQ-029 RECV, rx_bad_frame: wr_ptr <= sof; committed_prod unchanged; go to IDLE.
REQ-030 DROP: discard all beats; on rx_good_frame or rx_bad_frame, wr_ptr <= sof and go to IDLE.
REQ-031 committed_prod never points past unwritten data, and never changes except per REQ-027.
REQ-032 committed_cons may change on any cycle; free is re-evaluated every cycle.
REQ-033 byte_len saturates at 0xFFFF.

Reset
REQ-034 Reset values: wr_en=0, wr_addr=0, wr_data=0, committed_prod=0, wr_ptr=0, sof=0, byte_len=0, FSM=IDLE.
REQ-035 Reset asserted mid-frame discards the partial frame; no header is written and nothing is committed.

Configuration
REQ-036 Macro RX_DROP_CNT_EN defined: dropped_frames exists.
REQ-037 dropped_frames resets to 0; it increments (saturating at 0xFFFFFFFF) on every rx_bad_frame in RECV and on every frame exit from DROP.
REQ-038 Macro RX_DROP_CNT_EN undefined: no port and no counter logic; all other behaviour identical.

Verification
REQ-039 After reset, a 64-byte good frame (8 beats of 0xFF), BW=9 -> QWs 1..8 written; header 0x40 written at address 0; committed_prod=9 two cycles after the strobe.
REQ-040 A 61-byte frame (last valid=0x1F) -> header byte_len=61; committed_prod advances by 9.
REQ-041 A bad 64-byte frame, then a good 64-byte frame -> the second frame's header is at address 0; committed_prod=9; dropped_frames=1 under the macro.
REQ-042 committed_cons=0, wr_ptr=500, 20-QW frame -> DROP at the 12th QW; committed_prod stays 500; wr_ptr=500; the next frame is accepted once committed_cons=500.
REQ-043 Wrap case: wr_ptr=1020, committed_cons=1020, 8-QW frame -> addresses 1021..1023 then 0..4; committed_prod=1029 mod 1024 = 5 with bit BW set.
REQ-044 rst asserted in the middle of a frame -> wr_en=0 on the next cycle; committed_prod=0; the next frame's header is at address 0.
